// File: rtl/arm_dmem_responder.sv
// rtl/arm_dmem_responder.sv - data-memory responder with byte lanes, fault flag and end-of-run checksum scan
//
// Purpose: memory side of the core data port. Word-addressed reads and
// byte-lane writes with one registered cycle of read latency (write-first),
// a sticky out-of-range flag, and a post-halt walk of the whole array that
// produces a 32-bit wrap-around checksum.
//
// Ports:
//   clk_i           clock, all state changes on the rising edge
//   rst_i           synchronous active-high reset (memory contents kept)
//   mem_addr_i      word address from the core
//   mem_data_in_i   store data
//   mem_write_en_i  byte-lane enables, 4'b0000 is a read
//   halted_i        core halt level, starts the checksum scan
//   mem_data_out_o  registered read / merged-store data
//   addr_fault_o    sticky, set by any access at or beyond DEPTH
//   dump_busy_o     checksum scan in progress
//   dump_done_o     checksum valid, sticky until reset
//   checksum_o      sum of all words mod 2^32

module arm_dmem_responder #(
    parameter int DEPTH = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [29:0] mem_addr_i,
    input  logic [31:0] mem_data_in_i,
    input  logic [3:0]  mem_write_en_i,
    input  logic        halted_i,
    output logic [31:0] mem_data_out_o,
    output logic        addr_fault_o,
    output logic        dump_busy_o,
    output logic        dump_done_o,
    output logic [31:0] checksum_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   checksum_q, checksum_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          fault_q, fault_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [31:0]   mem [DEPTH];

    logic          in_range;
    logic [AW-1:0] word_addr;
    logic [31:0]   lane_mask;
    logic [31:0]   next_word;
    logic          mem_we;

    // Any set bit above the index field means the access is outside the array.
    assign in_range  = (mem_addr_i[29:AW] == '0);
    assign word_addr = mem_addr_i[AW-1:0];
    assign lane_mask = {{8{mem_write_en_i[3]}}, {8{mem_write_en_i[2]}},
                        {8{mem_write_en_i[1]}}, {8{mem_write_en_i[0]}}};
    assign next_word = (mem[word_addr] & ~lane_mask) | (mem_data_in_i & lane_mask);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        checksum_d = checksum_q;
        rdata_d    = rdata_q;
        fault_d    = fault_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        mem_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The port access of the halt-sampling cycle is still serviced.
                if (in_range) begin
                    rdata_d = next_word;
                    mem_we  = (mem_write_en_i != 4'b0000);
                end else begin
                    rdata_d = 32'h0;
                    fault_d = 1'b1;
                end
                if (halted_i) begin
                    state_d    = S_SCAN;
                    idx_d      = '0;
                    checksum_d = 32'h0;
                    busy_d     = 1'b1;
                end
            end
            S_SCAN: begin
                checksum_d = checksum_q + mem[idx_q];
                idx_d      = idx_q + AW'(1);
                busy_d     = 1'b1;
                if (idx_q == AW'(DEPTH - 1)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                end
            end
            S_DONE: begin
                // Flag follows the state by one edge, leaving a one-cycle
                // gap between busy falling and done rising.
                done_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            checksum_q <= 32'h0;
            rdata_q    <= 32'h0;
            fault_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            checksum_q <= checksum_d;
            rdata_q    <= rdata_d;
            fault_q    <= fault_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Array has no reset; a store presented together with rst is dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_i && mem_we) begin
            mem[word_addr] <= next_word;
        end
    end

    assign mem_data_out_o = rdata_q;
    assign addr_fault_o   = fault_q;
    assign dump_busy_o    = busy_q;
    assign dump_done_o    = done_q;
    assign checksum_o     = checksum_q;

endmodule
